match_sequencer: RTL and testbench

- Owns the 6x6 board's selection and hidden state and sequences the pair matcher.
- Collects player clicks into a 36-bit selection bus.
- Hands exactly two visible cards to the matcher and waits for a success or fail result.
- Retires matched pairs into the hidden bus and tracks pairs remaining; sits between the cursor/input logic and the matcher.

---
 rtl/match_sequencer.sv | 121 ++++++++++++
 tb/tb_match_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// Selection/hidden-state owner for a 6x6 memory board: collects two clicks,
// hands them to the pair matcher, and retires or releases them on its result.
module match_sequencer #(
  parameter int NUM_PAIRS    = 18,
  parameter int TIMEOUT_CYC  = 255,
  parameter int COOLDOWN_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        click,
  input  logic [5:0]  click_pos,
  input  logic        new_game,
  input  logic        en_input,
  input  logic        ms,
  input  logic        mf,
  output logic [35:0] sel_bus,
  output logic [35:0] hidden_bus,
  output logic [4:0]  pairs_left,
  output logic        match_pulse,
  output logic        miss_pulse,
  output logic        busy,
  output logic        win
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] COOLDOWN_END = TW'(COOLDOWN_CYC - 1);
  localparam logic [4:0]    PAIRS_INIT   = 5'(NUM_PAIRS);

  typedef enum logic [2:0] {IDLE, ONE, WAIT, COOLDOWN, WIN} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [35:0]   pos_mask;
  logic          click_ok;

  // Off-board positions decode to an empty mask, which also disqualifies the click.
  always_comb begin
    pos_mask = '0;
    if (click_pos < 6'd36) pos_mask = 36'd1 << click_pos;
    click_ok = click && (pos_mask != '0) && ((pos_mask & hidden_bus) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst || new_game) begin
      state       <= IDLE;
      timer       <= '0;
      sel_bus     <= '0;
      hidden_bus  <= '0;
      pairs_left  <= PAIRS_INIT;
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      busy        <= 1'b0;
      win         <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (click_ok) begin
            sel_bus <= pos_mask;
            state   <= ONE;
          end
        end
        ONE: begin
          if (click_ok) begin
            if ((pos_mask & sel_bus) != '0) begin
              sel_bus <= '0;
              state   <= IDLE;
            end else begin
              sel_bus <= sel_bus | pos_mask;
              timer   <= '0;
              busy    <= 1'b1;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (ms && (pairs_left != 5'd0)) begin
            hidden_bus  <= hidden_bus | sel_bus;
            sel_bus     <= '0;
            pairs_left  <= pairs_left - 5'd1;
            match_pulse <= 1'b1;
            timer       <= '0;
            state       <= COOLDOWN;
          end else if (mf || (timer == TIMEOUT_VAL)) begin
            sel_bus    <= '0;
            miss_pulse <= 1'b1;
            timer      <= '0;
            state      <= COOLDOWN;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        COOLDOWN: begin
          // Matcher results here are its re-evaluation of the cleared selection.
          if ((timer >= COOLDOWN_END) && en_input) begin
            busy  <= 1'b0;
            timer <= '0;
            if (pairs_left == 5'd0) begin
              win   <= 1'b1;
              state <= WIN;
            end else begin
              state <= IDLE;
            end
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        WIN: begin
          win <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed scenarios plus random play, compared
// every cycle against a queue-based model of the board rules.
module tb_match_sequencer;

  localparam int NUM_PAIRS    = 18;
  localparam int TIMEOUT_CYC  = 255;
  localparam int COOLDOWN_CYC = 8;

  logic        clk = 1'b0;
  logic        rst, click, new_game, en_input, ms, mf;
  logic [5:0]  click_pos;
  logic [35:0] sel_bus, hidden_bus;
  logic [4:0]  pairs_left;
  logic        match_pulse, miss_pulse, busy, win;

  match_sequencer #(
    .NUM_PAIRS(NUM_PAIRS), .TIMEOUT_CYC(TIMEOUT_CYC), .COOLDOWN_CYC(COOLDOWN_CYC)
  ) dut (
    .clk(clk), .rst(rst), .click(click), .click_pos(click_pos),
    .new_game(new_game), .en_input(en_input), .ms(ms), .mf(mf),
    .sel_bus(sel_bus), .hidden_bus(hidden_bus), .pairs_left(pairs_left),
    .match_pulse(match_pulse), .miss_pulse(miss_pulse), .busy(busy), .win(win)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int match_cnt = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the selection is an ordered list of clicked positions.
  localparam int PH_IDLE = 0, PH_ONE = 1, PH_WAIT = 2, PH_COOL = 3, PH_WIN = 4;
  int  m_phase;
  int  m_sel[$];
  bit  m_hid[36];
  int  m_pairs;
  int  m_cnt;
  bit  m_match, m_miss;
  bit  chk_en = 1'b0;

  function automatic logic [35:0] mask_of_sel();
    logic [35:0] m = '0;
    foreach (m_sel[i]) m[m_sel[i]] = 1'b1;
    return m;
  endfunction

  function automatic logic [35:0] mask_of_hid();
    logic [35:0] m = '0;
    for (int p = 0; p < 36; p++) m[p] = m_hid[p];
    return m;
  endfunction

  always @(posedge clk) begin
    int pos;
    pos = int'(click_pos);
    m_match = 1'b0;
    m_miss  = 1'b0;
    if (!rst || new_game) begin
      m_phase = PH_IDLE;
      m_sel.delete();
      for (int p = 0; p < 36; p++) m_hid[p] = 1'b0;
      m_pairs = NUM_PAIRS;
      m_cnt   = 0;
      chk_en  = 1'b1;
    end else begin
      case (m_phase)
        PH_IDLE, PH_ONE: begin
          if (click && pos < 36 && !m_hid[pos]) begin
            if (m_sel.size() == 0) begin
              m_sel.push_back(pos);
              m_phase = PH_ONE;
            end else if (m_sel[0] == pos) begin
              m_sel.delete();
              m_phase = PH_IDLE;
            end else begin
              m_sel.push_back(pos);
              m_phase = PH_WAIT;
              m_cnt = 0;
            end
          end
        end
        PH_WAIT: begin
          if (ms && m_pairs > 0) begin
            foreach (m_sel[i]) m_hid[m_sel[i]] = 1'b1;
            m_sel.delete();
            m_pairs--;
            m_match = 1'b1;
            m_phase = PH_COOL;
            m_cnt = 0;
          end else if (mf || m_cnt == TIMEOUT_CYC) begin
            m_sel.delete();
            m_miss = 1'b1;
            m_phase = PH_COOL;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        PH_COOL: begin
          if (m_cnt >= COOLDOWN_CYC - 1 && en_input) m_phase = (m_pairs == 0) ? PH_WIN : PH_IDLE;
          else m_cnt++;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sel_bus", 64'(sel_bus), 64'(mask_of_sel()));
      check("hidden_bus", 64'(hidden_bus), 64'(mask_of_hid()));
      check("pairs_left", 64'(pairs_left), 64'(m_pairs));
      check("match_pulse", 64'(match_pulse), 64'(m_match));
      check("miss_pulse", 64'(miss_pulse), 64'(m_miss));
      check("busy", 64'(busy), 64'(m_phase == PH_WAIT || m_phase == PH_COOL));
      check("win", 64'(win), 64'(m_phase == PH_WIN));
      if (match_pulse === 1'b1) match_cnt++;
      if (miss_pulse === 1'b1) miss_cnt++;
    end
  end

  task automatic do_click(input int pos);
    @(negedge clk);
    click = 1'b1;
    click_pos = 6'(pos);
    @(negedge clk);
    click = 1'b0;
  endtask

  task automatic do_result(input logic s, input logic f);
    @(negedge clk);
    ms = s;
    mf = f;
    @(negedge clk);
    ms = 1'b0;
    mf = 1'b0;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic wait_not_busy(input int max_cyc, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  initial begin
    int m0, avail[$];
    rst = 1'b0; click = 1'b0; click_pos = '0; new_game = 1'b0;
    en_input = 1'b1; ms = 1'b0; mf = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sel", 64'(sel_bus), 64'd0);
    check("reset_pairs", 64'(pairs_left), 64'd18);
    check("reset_busy_win", 64'({busy, win, match_pulse, miss_pulse}), 64'd0);
    rst = 1'b1;

    // Failed attempt on 7/8.
    do_click(7);
    do_click(8);
    check("t2_wait_sel", 64'(sel_bus), 64'h180);
    check("t2_wait_busy", 64'(busy), 64'd1);
    do_result(1'b0, 1'b1);
    check("t2_miss_pulse", 64'(miss_pulse), 64'd1);
    check("t2_sel", 64'(sel_bus), 64'd0);
    check("t2_pairs", 64'(pairs_left), 64'd18);
    wait_not_busy(40, "t2_cooldown_exit");

    // Successful pair 0/5.
    do_click(0);
    check("t1_one_sel", 64'(sel_bus), 64'h1);
    do_click(5);
    do_result(1'b1, 1'b0);
    check("t1_match_pulse", 64'(match_pulse), 64'd1);
    check("t1_hidden", 64'(hidden_bus), 64'h000000021);
    check("t1_pairs", 64'(pairs_left), 64'd17);
    @(negedge clk);
    check("t1_pulse_one_cycle", 64'(match_pulse), 64'd0);
    wait_not_busy(40, "t1_cooldown_exit");

    // Deselect, off-board click, hidden click.
    do_click(3);
    do_click(3);
    check("t3_deselect", 64'(sel_bus), 64'd0);
    do_click(40);
    do_click(0);
    check("t3_ignored", 64'(sel_bus), 64'd0);
    do_click(12);
    check("t3_sel12", 64'(sel_bus), 64'h1000);
    check("t3_not_busy", 64'(busy), 64'd0);
    do_click(12);

    // Timeout abort, click during cooldown ignored.
    do_click(1);
    do_click(2);
    m0 = miss_cnt;
    repeat (TIMEOUT_CYC + 5) begin
      if (miss_cnt == m0) @(negedge clk);
    end
    check("t4_abort_seen", 64'(miss_cnt - m0), 64'd1);
    check("t4_sel", 64'(sel_bus), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    do_click(6);
    check("t4_cool_click", 64'(sel_bus), 64'd0);
    wait_not_busy(40, "t4_cooldown_exit");

    // Clear the board.
    for (int p = 0; p < 36; p++) if (!m_hid[p]) avail.push_back(p);
    while (avail.size() >= 2) begin
      do_click(avail.pop_front());
      do_click(avail.pop_front());
      do_result(1'b1, 1'b0);
      wait_not_busy(40, "t5_cooldown_exit");
    end
    @(negedge clk);
    check("t5_win", 64'(win), 64'd1);
    check("t5_pairs", 64'(pairs_left), 64'd0);
    do_click(3);
    do_click(40);
    check("t5_click_ignored", 64'(sel_bus), 64'd0);
    pulse_new_game();
    check("t5_ng_hidden", 64'(hidden_bus), 64'd0);
    check("t5_ng_pairs", 64'(pairs_left), 64'd18);
    check("t5_ng_win", 64'(win), 64'd0);

    // Reset mid-WAIT with a result arriving during reset.
    do_click(4);
    do_click(9);
    m0 = match_cnt;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ms = 1'b1;
    @(negedge clk);
    ms = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_sel", 64'(sel_bus), 64'd0);
    check("t6_hidden", 64'(hidden_bus), 64'd0);
    check("t6_pairs", 64'(pairs_left), 64'd18);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_no_match", 64'(match_cnt - m0), 64'd0);

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      click     = ($urandom_range(99, 0) < 35);
      click_pos = 6'($urandom_range(39, 0));
      en_input  = ($urandom_range(99, 0) < 80);
      ms        = ($urandom_range(99, 0) < 8);
      mf        = ($urandom_range(99, 0) < 6);
      new_game  = ($urandom_range(999, 0) < 3);
      rst       = !($urandom_range(999, 0) < 3);
    end
    @(negedge clk);
    click = 1'b0; ms = 1'b0; mf = 1'b0; new_game = 1'b0; rst = 1'b1; en_input = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
